// File: rtl/snapshot_mem_arbiter.sv
// Round-robin arbiter sharing one snapshot-memory port among REQ_CNT requesters.
// Optional ack timeout enabled by defining SNAPSHOT_MEM_ARB_TIMEOUT_EN.
module snapshot_mem_arbiter #(
  parameter int unsigned REQ_CNT        = 4,
  parameter int unsigned ENTRY_WIDTH    = 7,
  parameter int unsigned MEM_WIDTH      = 36,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [REQ_CNT-1:0]             req_mem_req_vld,
  input  logic [REQ_CNT*ENTRY_WIDTH-1:0] req_mem_addr,
  input  logic [REQ_CNT-1:0]             req_mem_rd_en,
  input  logic [REQ_CNT-1:0]             req_mem_wr_en,
  input  logic [REQ_CNT*MEM_WIDTH-1:0]   req_mem_wr_data,
  output logic [REQ_CNT-1:0]             req_mem_ack_vld,
  output logic [MEM_WIDTH-1:0]           req_mem_rd_data,
  output logic                           mem_req_vld,
  output logic [ENTRY_WIDTH-1:0]         mem_addr,
  output logic                           mem_rd_en,
  output logic                           mem_wr_en,
  output logic [MEM_WIDTH-1:0]           mem_wr_data,
  input  logic [MEM_WIDTH-1:0]           mem_rd_data,
  input  logic                           mem_ack_vld,
  output logic                           arb_busy,
  output logic [REQ_CNT-1:0]             arb_grant
`ifdef SNAPSHOT_MEM_ARB_TIMEOUT_EN
  ,
  output logic                           arb_timeout_err
`endif
);

  localparam int unsigned PTR_W = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;

  if (REQ_CNT < 2 || REQ_CNT > 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
    $error("snapshot_mem_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE = 2'b01,
    BUSY = 2'b10
  } state_t;

  state_t             state;
  logic [REQ_CNT-1:0] grant_ff;
  logic [PTR_W-1:0]   rr_ptr;

  logic [REQ_CNT-1:0] pick_oh;
  logic [PTR_W-1:0]   g_idx;
  logic [PTR_W-1:0]   next_ptr;
  logic               busy;
  logic               g_req;
  logic               to_hit;
  logic               release_now;

  // First requester at or after rr_ptr, wrapping around.
  always_comb begin
    logic found;
    found   = 1'b0;
    pick_oh = '0;
    for (int unsigned k = 0; k < REQ_CNT; k++) begin
      int unsigned idx;
      idx = (32'(rr_ptr) + k) % REQ_CNT;
      if (!found && req_mem_req_vld[idx]) begin
        pick_oh[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  // Encode the held grant and compute the pointer after release.
  always_comb begin
    g_idx = '0;
    for (int unsigned i = 0; i < REQ_CNT; i++) begin
      if (grant_ff[i]) g_idx = PTR_W'(i);
    end
    next_ptr = (32'(g_idx) == REQ_CNT - 1) ? '0 : PTR_W'(g_idx + 1'b1);
  end

  assign busy  = (state == BUSY);
  assign g_req = |(req_mem_req_vld & grant_ff);

`ifdef SNAPSHOT_MEM_ARB_TIMEOUT_EN
  logic [15:0] to_cnt;
  assign to_hit          = busy && g_req && !mem_ack_vld && (to_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign arb_timeout_err = to_hit;
`else
  assign to_hit = 1'b0;
`endif

  assign release_now = busy && (mem_ack_vld || !g_req || to_hit);

  // Ack goes only to the granted requester; stray acks in IDLE are dropped.
  assign req_mem_ack_vld = (busy && (mem_ack_vld || to_hit)) ? grant_ff : '0;
  assign req_mem_rd_data = to_hit ? '0 : mem_rd_data;
  assign arb_busy        = busy;
  assign arb_grant       = grant_ff;

  // Downstream mux, gated by the granted requester's own request.
  always_comb begin
    mem_req_vld = 1'b0;
    mem_addr    = '0;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    for (int unsigned i = 0; i < REQ_CNT; i++) begin
      if (busy && grant_ff[i] && req_mem_req_vld[i]) begin
        mem_req_vld = 1'b1;
        mem_addr    = mem_addr | req_mem_addr[i*ENTRY_WIDTH +: ENTRY_WIDTH];
        mem_rd_en   = mem_rd_en | req_mem_rd_en[i];
        mem_wr_en   = mem_wr_en | req_mem_wr_en[i];
        mem_wr_data = mem_wr_data | req_mem_wr_data[i*MEM_WIDTH +: MEM_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant_ff <= '0;
      rr_ptr   <= '0;
`ifdef SNAPSHOT_MEM_ARB_TIMEOUT_EN
      to_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
`ifdef SNAPSHOT_MEM_ARB_TIMEOUT_EN
          to_cnt <= '0;
`endif
          if (|req_mem_req_vld) begin
            grant_ff <= pick_oh;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (release_now) begin
            grant_ff <= '0;
            rr_ptr   <= next_ptr;
            state    <= IDLE;
          end
`ifdef SNAPSHOT_MEM_ARB_TIMEOUT_EN
          else begin
            to_cnt <= to_cnt + 16'd1;
          end
`endif
        end
        default: begin
          state    <= IDLE;
          grant_ff <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snapshot_mem_arbiter.sv
// Directed self-checking bench for snapshot_mem_arbiter (REQ_CNT=4).
module tb_snapshot_mem_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 7;
  localparam int unsigned DW = 36;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_vld;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_rd_en;
  logic [N-1:0]    req_wr_en;
  logic [N*DW-1:0] req_wr_data;
  logic [N-1:0]    ack;
  logic [DW-1:0]   rd_data_b;
  logic            mem_req_vld;
  logic [AW-1:0]   mem_addr;
  logic            mem_rd_en;
  logic            mem_wr_en;
  logic [DW-1:0]   mem_wr_data;
  logic [DW-1:0]   mem_rd_data;
  logic            mem_ack_vld;
  logic            arb_busy;
  logic [N-1:0]    arb_grant;
`ifdef SNAPSHOT_MEM_ARB_TIMEOUT_EN
  logic            arb_timeout_err;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  snapshot_mem_arbiter #(
    .REQ_CNT(N), .ENTRY_WIDTH(AW), .MEM_WIDTH(DW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .req_mem_req_vld(req_vld), .req_mem_addr(req_addr),
    .req_mem_rd_en(req_rd_en), .req_mem_wr_en(req_wr_en),
    .req_mem_wr_data(req_wr_data), .req_mem_ack_vld(ack),
    .req_mem_rd_data(rd_data_b), .mem_req_vld(mem_req_vld),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .mem_ack_vld(mem_ack_vld), .arb_busy(arb_busy), .arb_grant(arb_grant)
`ifdef SNAPSHOT_MEM_ARB_TIMEOUT_EN
    , .arb_timeout_err(arb_timeout_err)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_vld = '0; req_addr = '0; req_rd_en = '0; req_wr_en = '0;
    req_wr_data = '0; mem_rd_data = '0; mem_ack_vld = 1'b0;
    step(); step();
    rst = 1'b0;
    settle();
  endtask

  task automatic test_reset();
    do_reset();
    mem_rd_data = 36'h1_2345_6789;
    settle();
    checks++; if (arb_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", arb_busy); end
    checks++; if (arb_grant !== 4'b0000) begin failures++; $display("FAIL rst_grant got=%b exp=0000", arb_grant); end
    checks++; if ({mem_req_vld, mem_rd_en, mem_wr_en} !== 3'b000) begin failures++; $display("FAIL rst_mem_ctl got=%b exp=000", {mem_req_vld, mem_rd_en, mem_wr_en}); end
    checks++; if (mem_addr !== 7'h00 || mem_wr_data !== 36'h0) begin failures++; $display("FAIL rst_mem_data got=%h/%h exp=0/0", mem_addr, mem_wr_data); end
    checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL rst_ack got=%b exp=0000", ack); end
    checks++; if (rd_data_b !== 36'h1_2345_6789) begin failures++; $display("FAIL rst_rd_bcast got=%h exp=123456789", rd_data_b); end
  endtask

  task automatic test_single_read();
    do_reset();
    req_vld[2] = 1'b1; req_rd_en[2] = 1'b1; req_addr[2*AW +: AW] = 7'h15;
    settle();
    checks++; if (arb_grant !== 4'b0000 || mem_req_vld !== 1'b0) begin failures++; $display("FAIL sr_latency got=%b/%b exp=0000/0", arb_grant, mem_req_vld); end
    step();
    checks++; if (arb_grant !== 4'b0100) begin failures++; $display("FAIL sr_grant got=%b exp=0100", arb_grant); end
    checks++; if (mem_req_vld !== 1'b1 || mem_rd_en !== 1'b1 || mem_addr !== 7'h15) begin failures++; $display("FAIL sr_mux got=%b/%b/%h exp=1/1/15", mem_req_vld, mem_rd_en, mem_addr); end
    step(); step(); step();
    checks++; if (arb_busy !== 1'b1 || ack !== 4'b0000) begin failures++; $display("FAIL sr_wait got=%b/%b exp=1/0000", arb_busy, ack); end
    mem_ack_vld = 1'b1; mem_rd_data = 36'h9_1234_5678;
    settle();
    checks++; if (ack !== 4'b0100) begin failures++; $display("FAIL sr_ack got=%b exp=0100", ack); end
    checks++; if (rd_data_b !== 36'h9_1234_5678) begin failures++; $display("FAIL sr_rdata got=%h exp=912345678", rd_data_b); end
    step();
    mem_ack_vld = 1'b0; req_vld = '0; req_rd_en = '0;
    settle();
    checks++; if (arb_busy !== 1'b0 || arb_grant !== 4'b0000) begin failures++; $display("FAIL sr_release got=%b/%b exp=0/0000", arb_busy, arb_grant); end
    // rr_ptr is now 3: requester 3 must beat requester 0.
    req_vld = 4'b1001;
    step();
    checks++; if (arb_grant !== 4'b1000) begin failures++; $display("FAIL sr_rrptr got=%b exp=1000", arb_grant); end
    mem_ack_vld = 1'b1;
    step();
    mem_ack_vld = 1'b0; req_vld = '0;
    settle();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_g;
    do_reset();
    req_vld = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      exp_g = 4'(1 << (i % 4));
      step();
      checks++; if (arb_grant !== exp_g) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b", i, arb_grant, exp_g); end
      mem_ack_vld = 1'b1;
      settle();
      checks++; if (ack !== exp_g) begin failures++; $display("FAIL rr_ack%0d got=%b exp=%b", i, ack, exp_g); end
      step();
      mem_ack_vld = 1'b0;
      settle();
      checks++; if (arb_busy !== 1'b0 || arb_grant !== 4'b0000) begin failures++; $display("FAIL rr_idle%0d got=%b/%b exp=0/0000", i, arb_busy, arb_grant); end
    end
    req_vld = '0;
  endtask

  task automatic test_write_mux();
    do_reset();
    req_vld[1] = 1'b1; req_wr_en[1] = 1'b1; req_addr[1*AW +: AW] = 7'h7F;
    req_wr_data[1*DW +: DW] = 36'hF_0000_0001;
    req_wr_en[3] = 1'b1; req_rd_en[3] = 1'b1; req_addr[3*AW +: AW] = 7'h2A;
    req_wr_data[3*DW +: DW] = 36'hA_5A5A_5A5A;
    settle();
    checks++; if (mem_wr_en !== 1'b0 || mem_wr_data !== 36'h0) begin failures++; $display("FAIL wm_idle got=%b/%h exp=0/0", mem_wr_en, mem_wr_data); end
    step();
    checks++; if (arb_grant !== 4'b0010) begin failures++; $display("FAIL wm_grant got=%b exp=0010", arb_grant); end
    checks++; if (mem_wr_en !== 1'b1 || mem_rd_en !== 1'b0 || mem_addr !== 7'h7F || mem_wr_data !== 36'hF_0000_0001) begin failures++; $display("FAIL wm_mux got=%b/%b/%h/%h exp=1/0/7f/f00000001", mem_wr_en, mem_rd_en, mem_addr, mem_wr_data); end
    mem_ack_vld = 1'b1;
    settle();
    checks++; if (ack !== 4'b0010) begin failures++; $display("FAIL wm_ack got=%b exp=0010", ack); end
    step();
    mem_ack_vld = 1'b0; req_vld = '0; req_wr_en = '0; req_rd_en = '0;
    settle();
    checks++; if (mem_wr_en !== 1'b0 || mem_wr_data !== 36'h0 || mem_addr !== 7'h00) begin failures++; $display("FAIL wm_after got=%b/%h/%h exp=0/0/0", mem_wr_en, mem_wr_data, mem_addr); end
  endtask

  task automatic test_abort();
    do_reset();
    req_vld = 4'b0011;
    step();
    checks++; if (arb_grant !== 4'b0001) begin failures++; $display("FAIL ab_grant got=%b exp=0001", arb_grant); end
    step(); step();
    req_vld[0] = 1'b0;
    settle();
    checks++; if (mem_req_vld !== 1'b0 || ack !== 4'b0000) begin failures++; $display("FAIL ab_drop got=%b/%b exp=0/0000", mem_req_vld, ack); end
    step();
    checks++; if (arb_busy !== 1'b0 || arb_grant !== 4'b0000 || ack !== 4'b0000) begin failures++; $display("FAIL ab_idle got=%b/%b/%b exp=0/0000/0000", arb_busy, arb_grant, ack); end
    step();
    checks++; if (arb_grant !== 4'b0010 || mem_req_vld !== 1'b1) begin failures++; $display("FAIL ab_next got=%b/%b exp=0010/1", arb_grant, mem_req_vld); end
    mem_ack_vld = 1'b1;
    step();
    mem_ack_vld = 1'b0; req_vld = '0;
    settle();
  endtask

  task automatic test_reset_stray_ack();
    do_reset();
    req_vld[2] = 1'b1; req_rd_en[2] = 1'b1; req_addr[2*AW +: AW] = 7'h33;
    step();
    checks++; if (arb_busy !== 1'b1) begin failures++; $display("FAIL rs_busy got=%b exp=1", arb_busy); end
    rst = 1'b1;
    step();
    rst = 1'b0; req_vld = '0; req_rd_en = '0;
    settle();
    checks++; if (arb_busy !== 1'b0 || arb_grant !== 4'b0000 || mem_req_vld !== 1'b0 || mem_addr !== 7'h00 || mem_rd_en !== 1'b0) begin failures++; $display("FAIL rs_outs got=%b/%b/%b/%h/%b exp=0/0000/0/00/0", arb_busy, arb_grant, mem_req_vld, mem_addr, mem_rd_en); end
    mem_ack_vld = 1'b1; mem_rd_data = 36'h5_5555_AAAA;
    settle();
    checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL rs_stray got=%b exp=0000", ack); end
    checks++; if (rd_data_b !== 36'h5_5555_AAAA) begin failures++; $display("FAIL rs_bcast got=%h exp=55555aaaa", rd_data_b); end
    step();
    mem_ack_vld = 1'b0;
    settle();
    checks++; if (arb_busy !== 1'b0) begin failures++; $display("FAIL rs_stay got=%b exp=0", arb_busy); end
  endtask

`ifdef SNAPSHOT_MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    req_vld[1] = 1'b1; req_rd_en[1] = 1'b1; mem_rd_data = 36'h7_7777_7777;
    step();
    for (int c = 1; c < 8; c++) begin
      checks++; if (ack !== 4'b0000 || arb_timeout_err !== 1'b0) begin failures++; $display("FAIL to_wait%0d got=%b/%b exp=0000/0", c, ack, arb_timeout_err); end
      step();
    end
    checks++; if (ack !== 4'b0010 || rd_data_b !== 36'h0 || arb_timeout_err !== 1'b1) begin failures++; $display("FAIL to_fire got=%b/%h/%b exp=0010/0/1", ack, rd_data_b, arb_timeout_err); end
    step();
    req_vld = '0; req_rd_en = '0;
    mem_ack_vld = 1'b1;
    settle();
    checks++; if (arb_busy !== 1'b0 || ack !== 4'b0000 || arb_timeout_err !== 1'b0) begin failures++; $display("FAIL to_after got=%b/%b/%b exp=0/0000/0", arb_busy, ack, arb_timeout_err); end
    step();
    mem_ack_vld = 1'b0;
    settle();
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_mux();
    test_abort();
    test_reset_stray_ack();
`ifdef SNAPSHOT_MEM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
